// File: rtl/i2s_rx.sv
// ---------------------------------------------------------------------------
// i2s_rx
//   I2S (Philips format) receiver for the codec ADC path. The codec-driven
//   SCLK/LRCLK/SDATA lines are oversampled on CLK through matched
//   synchronisers, then the left and right words are deserialised MSB-first.
//   Each complete left+right pair is presented on SAMPLE_L/SAMPLE_R with a
//   one-cycle SAMPLE_VALID pulse, and a floor-halved mono mix is written to
//   a CLK-domain sample FIFO unless that FIFO reports full.
//
// Ports
//   CLK          system clock (>= 8x SCLK)
//   RESET_N      asynchronous active-low reset
//   ENABLE       1 = receive, 0 = abort current frame and sit idle
//   SCLK_IN      I2S bit clock (async)
//   LRCLK_IN     I2S word select, 0 = left, 1 = right (async)
//   SDATA_IN     I2S serial data (async)
//   FIFO_FULL    sample FIFO full flag
//   FIFO_WRITE   one-cycle write strobe, FIFO_DATA valid with it
//   FIFO_DATA    mono sample (holds between writes)
//   SAMPLE_L/R   last complete left/right words
//   SAMPLE_VALID one-cycle pulse when a new L/R pair is presented
//   FRAME_ERR    one-cycle pulse when a short word aborts a frame
//   OVERFLOW     sticky, a frame was dropped because FIFO_FULL was set
//   DROP_COUNT   saturating count of dropped frames
// ---------------------------------------------------------------------------
module i2s_rx #(
  parameter int DATA_WIDTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  ENABLE,
  input  logic                  SCLK_IN,
  input  logic                  LRCLK_IN,
  input  logic                  SDATA_IN,
  input  logic                  FIFO_FULL,
  output logic                  FIFO_WRITE,
  output logic [DATA_WIDTH-1:0] FIFO_DATA,
  output logic [DATA_WIDTH-1:0] SAMPLE_L,
  output logic [DATA_WIDTH-1:0] SAMPLE_R,
  output logic                  SAMPLE_VALID,
  output logic                  FRAME_ERR,
  output logic                  OVERFLOW,
  output logic [7:0]            DROP_COUNT
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_HOLD} state_t;
  typedef enum logic {CH_L = 1'b0, CH_R = 1'b1} chan_t;

  // Input synchronisers: all three lines get the same delay so SDATA and
  // LRCLK stay aligned with the SCLK edge that samples them.
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] lr_sync_q, lr_sync_d;
  logic [SYNC_STAGES-1:0] sd_sync_q, sd_sync_d;
  logic                   hist_sclk_q, hist_sclk_d;
  logic                   lr_prev_q, lr_prev_d;

  logic sclk_s, lr_s, sd_s;
  logic sclk_rise, lr_edge;

  state_t                state_q, state_d;
  chan_t                 chan_q, chan_d;
  logic [CNT_W-1:0]      bitcnt_q, bitcnt_d;
  logic [DATA_WIDTH-1:0] sr_q, sr_d;
  logic [DATA_WIDTH-1:0] left_buf_q, left_buf_d;
  logic                  frame_done_q, frame_done_d;
  logic                  frame_err_q, frame_err_d;

  logic                  sample_valid_q, sample_valid_d;
  logic [DATA_WIDTH-1:0] sample_l_q, sample_l_d;
  logic [DATA_WIDTH-1:0] sample_r_q, sample_r_d;
  logic                  fifo_write_q, fifo_write_d;
  logic [DATA_WIDTH-1:0] fifo_data_q, fifo_data_d;
  logic                  overflow_q, overflow_d;
  logic [7:0]            drop_count_q, drop_count_d;

  logic                  fire;
  logic [DATA_WIDTH:0]   sum;
  logic [DATA_WIDTH-1:0] mono;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign lr_s      = lr_sync_q[SYNC_STAGES-1];
  assign sd_s      = sd_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~hist_sclk_q;
  assign lr_edge   = sclk_rise & (lr_s != lr_prev_q);

  // Sign-extended sum, then arithmetic shift right by one (floor).
  assign sum  = {left_buf_q[DATA_WIDTH-1], left_buf_q} + {sr_q[DATA_WIDTH-1], sr_q};
  assign mono = DATA_WIDTH'(sum >> 1);

  // A completed pair is only published while still enabled, so disabling in
  // the cycle after the right LSB still suppresses every pulse.
  assign fire = frame_done_q & ENABLE;

  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], SCLK_IN};
    lr_sync_d   = {lr_sync_q[SYNC_STAGES-2:0], LRCLK_IN};
    sd_sync_d   = {sd_sync_q[SYNC_STAGES-2:0], SDATA_IN};
    hist_sclk_d = sclk_s;
    // lr_prev keeps tracking even while disabled so that re-enabling picks
    // up the next genuine LRCLK falling edge rather than a stale one.
    lr_prev_d   = sclk_rise ? lr_s : lr_prev_q;
  end

  // Next-state logic. The rise that reveals an LRCLK edge carries the last
  // bit of the previous slot, so it never shifts data.
  always_comb begin
    state_d      = state_q;
    chan_d       = chan_q;
    bitcnt_d     = bitcnt_q;
    sr_d         = sr_q;
    left_buf_d   = left_buf_q;
    frame_done_d = 1'b0;
    frame_err_d  = 1'b0;

    if (!ENABLE) begin
      state_d  = ST_IDLE;
      bitcnt_d = '0;
    end else if (sclk_rise) begin
      case (state_q)
        ST_IDLE: begin
          // Only the start of a left slot can open a frame; a right slot
          // seen first is skipped silently.
          if (lr_edge && !lr_s) begin
            state_d  = ST_SHIFT;
            chan_d   = CH_L;
            bitcnt_d = '0;
          end
        end
        ST_SHIFT: begin
          if (lr_edge) begin
            // Word cut short: drop the frame and resync immediately if
            // the new slot is a left one.
            frame_err_d = 1'b1;
            bitcnt_d    = '0;
            chan_d      = CH_L;
            state_d     = lr_s ? ST_IDLE : ST_SHIFT;
          end else begin
            sr_d     = {sr_q[DATA_WIDTH-2:0], sd_s};
            bitcnt_d = bitcnt_q + CNT_W'(1);
            if (bitcnt_q == CNT_W'(DATA_WIDTH - 1)) begin
              state_d = ST_HOLD;
              if (chan_q == CH_L) begin
                left_buf_d = sr_d;
              end else begin
                frame_done_d = 1'b1;
              end
            end
          end
        end
        ST_HOLD: begin
          // Extra slot bits are ignored until the next word select edge.
          if (lr_edge) begin
            state_d  = ST_SHIFT;
            bitcnt_d = '0;
            chan_d   = lr_s ? CH_R : CH_L;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    sample_valid_d = fire;
    sample_l_d     = fire ? left_buf_q : sample_l_q;
    sample_r_d     = fire ? sr_q : sample_r_q;
    fifo_write_d   = fire & ~FIFO_FULL;
    fifo_data_d    = (fire && !FIFO_FULL) ? mono : fifo_data_q;
    overflow_d     = overflow_q | (fire & FIFO_FULL);
    drop_count_d   = drop_count_q;
    if (fire && FIFO_FULL && (drop_count_q != 8'hFF)) begin
      drop_count_d = drop_count_q + 8'd1;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      sclk_sync_q  <= '0;
      lr_sync_q    <= '0;
      sd_sync_q    <= '0;
      hist_sclk_q  <= 1'b0;
      lr_prev_q    <= 1'b0;
      state_q      <= ST_IDLE;
      chan_q       <= CH_L;
      bitcnt_q     <= '0;
      sr_q         <= '0;
      left_buf_q   <= '0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      sclk_sync_q  <= sclk_sync_d;
      lr_sync_q    <= lr_sync_d;
      sd_sync_q    <= sd_sync_d;
      hist_sclk_q  <= hist_sclk_d;
      lr_prev_q    <= lr_prev_d;
      state_q      <= state_d;
      chan_q       <= chan_d;
      bitcnt_q     <= bitcnt_d;
      sr_q         <= sr_d;
      left_buf_q   <= left_buf_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      sample_valid_q <= 1'b0;
      sample_l_q     <= '0;
      sample_r_q     <= '0;
      fifo_write_q   <= 1'b0;
      fifo_data_q    <= '0;
      overflow_q     <= 1'b0;
      drop_count_q   <= '0;
    end else begin
      sample_valid_q <= sample_valid_d;
      sample_l_q     <= sample_l_d;
      sample_r_q     <= sample_r_d;
      fifo_write_q   <= fifo_write_d;
      fifo_data_q    <= fifo_data_d;
      overflow_q     <= overflow_d;
      drop_count_q   <= drop_count_d;
    end
  end

  assign FIFO_WRITE   = fifo_write_q;
  assign FIFO_DATA    = fifo_data_q;
  assign SAMPLE_L     = sample_l_q;
  assign SAMPLE_R     = sample_r_q;
  assign SAMPLE_VALID = sample_valid_q;
  assign FRAME_ERR    = frame_err_q;
  assign OVERFLOW     = overflow_q;
  assign DROP_COUNT   = drop_count_q;

endmodule

// File: tb/tb_i2s_rx.sv
// ---------------------------------------------------------------------------
// tb_i2s_rx
//   Drives an I2S bus-functional model into i2s_rx and checks each published
//   frame against an expectation queue filled by the stimulus code.
// ---------------------------------------------------------------------------
module tb_i2s_rx;

  localparam int DW      = 16;
  localparam int SYNC    = 2;
  localparam int LAT_MAX = SYNC + 3;

  logic          CLK;
  logic          RESET_N;
  logic          ENABLE;
  logic          SCLK_IN;
  logic          LRCLK_IN;
  logic          SDATA_IN;
  logic          FIFO_FULL;
  logic          FIFO_WRITE;
  logic [DW-1:0] FIFO_DATA;
  logic [DW-1:0] SAMPLE_L;
  logic [DW-1:0] SAMPLE_R;
  logic          SAMPLE_VALID;
  logic          FRAME_ERR;
  logic          OVERFLOW;
  logic [7:0]    DROP_COUNT;

  i2s_rx #(.DATA_WIDTH(DW), .SYNC_STAGES(SYNC)) dut (
    .CLK          (CLK),
    .RESET_N      (RESET_N),
    .ENABLE       (ENABLE),
    .SCLK_IN      (SCLK_IN),
    .LRCLK_IN     (LRCLK_IN),
    .SDATA_IN     (SDATA_IN),
    .FIFO_FULL    (FIFO_FULL),
    .FIFO_WRITE   (FIFO_WRITE),
    .FIFO_DATA    (FIFO_DATA),
    .SAMPLE_L     (SAMPLE_L),
    .SAMPLE_R     (SAMPLE_R),
    .SAMPLE_VALID (SAMPLE_VALID),
    .FRAME_ERR    (FRAME_ERR),
    .OVERFLOW     (OVERFLOW),
    .DROP_COUNT   (DROP_COUNT)
  );

  typedef struct {
    logic [DW-1:0] l;
    logic [DW-1:0] r;
    logic [DW-1:0] mono;
  } vec_t;

  vec_t tbl[6];
  vec_t exp_q[$];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int lsb_cyc  = 0;
  int half     = 4;
  int val_cnt  = 0;
  int wr_cnt   = 0;
  int err_cnt  = 0;
  int drops    = 0;
  logic [DW-1:0] last_wr = '0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc++;

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input bit ok, input int act, input int req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic chk_eq(input string name, input int act, input int req);
    chk(name, act == req, act, req);
  endtask

  // Mono reference: signed average rounded toward minus infinity.
  function automatic logic [DW-1:0] model_mono(input logic [DW-1:0] l, input logic [DW-1:0] r);
    int s;
    s = int'($signed(l)) + int'($signed(r));
    return DW'(s >>> 1);
  endfunction

  // One slot of len SCLK periods: position 0 carries the previous slot's
  // tail, positions 1..16 the word MSB-first, the rest random padding.
  // Lines change right after SCLK falls; the receiver samples on rises.
  task automatic send_slot(input logic lr, input logic [DW-1:0] w, input int len);
    for (int k = 0; k < len; k++) begin
      LRCLK_IN = lr;
      SDATA_IN = (k >= 1 && k <= DW) ? w[DW-k] : 1'($urandom);
      repeat (half) @(negedge CLK);
      SCLK_IN = 1'b1;
      if (lr && k == DW) lsb_cyc = cyc;
      repeat (half) @(negedge CLK);
      SCLK_IN = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [DW-1:0] l, input logic [DW-1:0] r,
                            input logic [DW-1:0] mono, input bit expect_out, input int len);
    vec_t e;
    e.l = l; e.r = r; e.mono = mono;
    if (expect_out) exp_q.push_back(e);
    $display("frame L=%04h R=%04h mono=%04h expect=%0d slot=%0d full=%0d", l, r, mono, expect_out, len, FIFO_FULL);
    send_slot(1'b0, l, len);
    send_slot(1'b1, r, len);
  endtask

  task automatic send_rand(input bit expect_out, input int len);
    logic [DW-1:0] l, r;
    l = DW'($urandom);
    r = DW'($urandom);
    send_frame(l, r, model_mono(l, r), expect_out, len);
  endtask

  task automatic settle();
    repeat (8) @(negedge CLK);
  endtask

  task automatic check_all_zero(input string tag);
    chk_eq({tag, "_fifo_write"}, FIFO_WRITE, 0);
    chk_eq({tag, "_fifo_data"}, FIFO_DATA, 0);
    chk_eq({tag, "_sample_l"}, SAMPLE_L, 0);
    chk_eq({tag, "_sample_r"}, SAMPLE_R, 0);
    chk_eq({tag, "_sample_valid"}, SAMPLE_VALID, 0);
    chk_eq({tag, "_frame_err"}, FRAME_ERR, 0);
    chk_eq({tag, "_overflow"}, OVERFLOW, 0);
    chk_eq({tag, "_drop_count"}, DROP_COUNT, 0);
  endtask

  // Scoreboard: every SAMPLE_VALID must match the oldest expected frame.
  always @(negedge CLK) begin
    vec_t e;
    int lat;
    if (!RESET_N) begin
      last_wr = '0;
      drops   = 0;
    end else begin
      if (FRAME_ERR) err_cnt++;
      if (FIFO_WRITE) wr_cnt++;
      if (FIFO_WRITE && !SAMPLE_VALID) chk("write_without_valid", 1'b0, 1, 0);
      if (SAMPLE_VALID) begin
        val_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", 1'b0, 1, 0);
        end else begin
          e = exp_q.pop_front();
          lat = cyc - lsb_cyc;
          $display("valid L=%04h R=%04h wr=%0d data=%04h lat=%0d", SAMPLE_L, SAMPLE_R, FIFO_WRITE, FIFO_DATA, lat);
          chk_eq("sample_l", SAMPLE_L, e.l);
          chk_eq("sample_r", SAMPLE_R, e.r);
          chk_eq("fifo_write", FIFO_WRITE, int'(!FIFO_FULL));
          if (FIFO_FULL) drops++;
          if (FIFO_WRITE) begin
            chk_eq("fifo_data", FIFO_DATA, e.mono);
            last_wr = e.mono;
          end else begin
            chk_eq("fifo_data_hold", FIFO_DATA, last_wr);
          end
          chk("latency", lat >= 1 && lat <= LAT_MAX, lat, LAT_MAX);
        end
      end
    end
  end

  int v0, w0, e0;

  initial begin
    tbl[0] = '{l: 16'h1234, r: 16'h5678, mono: 16'h3456};
    tbl[1] = '{l: 16'hFFFF, r: 16'h0001, mono: 16'h0000};
    tbl[2] = '{l: 16'h8000, r: 16'h8000, mono: 16'h8000};
    tbl[3] = '{l: 16'h7FFF, r: 16'h7FFF, mono: 16'h7FFF};
    tbl[4] = '{l: 16'hFFFF, r: 16'h0000, mono: 16'hFFFF};
    tbl[5] = '{l: 16'h00F0, r: 16'h0F00, mono: 16'h07F8};

    RESET_N = 1'b0; ENABLE = 1'b0; SCLK_IN = 1'b0; LRCLK_IN = 1'b0;
    SDATA_IN = 1'b0; FIFO_FULL = 1'b0;
    repeat (3) @(negedge CLK);
    check_all_zero("reset");
    RESET_N = 1'b1; ENABLE = 1'b1;
    repeat (2) @(negedge CLK);

    // Start in the middle of a right word: nothing may come out of it.
    send_slot(1'b1, 16'h5A5A, 9);

    // 64fs stream, 10 consecutive frames.
    v0 = val_cnt; w0 = wr_cnt; e0 = err_cnt;
    for (int i = 0; i < 10; i++) send_frame(16'h1234, 16'h5678, 16'h3456, 1'b1, 32);
    settle();
    chk_eq("t1_valids", val_cnt - v0, 10);
    chk_eq("t1_writes", wr_cnt - w0, 10);
    chk_eq("t1_errs", err_cnt - e0, 0);
    chk_eq("t1_pending", exp_q.size(), 0);

    // Sign and rounding table.
    for (int i = 0; i < 6; i++) begin
      send_frame(tbl[i].l, tbl[i].r, tbl[i].mono, 1'b1, 17);
      settle();
      chk_eq("tbl_fifo_data", FIFO_DATA, tbl[i].mono);
      chk_eq("tbl_pending", exp_q.size(), 0);
    end

    // Random frames against the arithmetic model, mixed slot lengths.
    v0 = val_cnt;
    for (int i = 0; i < 8; i++) send_rand(1'b1, (i % 2 == 1) ? 17 : 24);
    settle();
    chk_eq("rand_valids", val_cnt - v0, 8);
    chk_eq("rand_pending", exp_q.size(), 0);

    // Short left word: LRCLK toggles after 10 bits.
    v0 = val_cnt; e0 = err_cnt;
    send_slot(1'b0, 16'hABCD, 11);
    send_slot(1'b1, 16'h1111, 17);
    send_frame(16'h00F0, 16'h0F00, 16'h07F8, 1'b1, 17);
    settle();
    chk_eq("short_errs", err_cnt - e0, 1);
    chk_eq("short_valids", val_cnt - v0, 1);
    chk_eq("short_fifo_data", FIFO_DATA, 16'h07F8);
    chk_eq("short_pending", exp_q.size(), 0);

    // Reset for 3 CLK in the middle of a left word.
    send_slot(1'b0, 16'hC3C3, 8);
    RESET_N = 1'b0;
    @(negedge CLK);
    check_all_zero("rst_mid");
    repeat (2) @(negedge CLK);
    RESET_N = 1'b1;
    v0 = val_cnt;
    send_slot(1'b1, 16'h3C3C, 17);
    settle();
    chk_eq("rst_no_valid", val_cnt - v0, 0);
    send_rand(1'b1, 17);
    settle();
    chk_eq("rst_first_valid", val_cnt - v0, 1);
    chk_eq("rst_pending", exp_q.size(), 0);

    // ENABLE dropped in the middle of the right word.
    v0 = val_cnt; e0 = err_cnt;
    send_slot(1'b0, 16'h1357, 17);
    send_slot(1'b1, 16'h2468, 12);
    ENABLE = 1'b0;
    send_slot(1'b1, 16'h9999, 10);
    settle();
    chk_eq("dis_valids", val_cnt - v0, 0);
    chk_eq("dis_errs", err_cnt - e0, 0);
    ENABLE = 1'b1;
    send_rand(1'b1, 17);
    settle();
    chk_eq("reen_valids", val_cnt - v0, 1);
    chk_eq("reen_pending", exp_q.size(), 0);

    // Slow bit clock (32x); latency checked per frame by the scoreboard.
    half = 16;
    send_rand(1'b1, 17);
    send_rand(1'b1, 17);
    settle();
    half = 4;
    chk_eq("slow_pending", exp_q.size(), 0);

    // FIFO full for 256 frames: drops saturate, no writes.
    chk_eq("pre_full_overflow", OVERFLOW, 0);
    chk_eq("pre_full_drops", DROP_COUNT, 0);
    FIFO_FULL = 1'b1;
    v0 = val_cnt; w0 = wr_cnt;
    for (int i = 0; i < 256; i++) send_rand(1'b1, 17);
    settle();
    chk_eq("full_writes", wr_cnt - w0, 0);
    chk_eq("full_valids", val_cnt - v0, 256);
    chk_eq("full_overflow", OVERFLOW, 1);
    chk_eq("full_drop_count", DROP_COUNT, (drops > 255) ? 255 : drops);
    chk_eq("full_drop_sat", DROP_COUNT, 255);
    chk_eq("full_pending", exp_q.size(), 0);
    FIFO_FULL = 1'b0;
    settle();
    w0 = wr_cnt;
    send_rand(1'b1, 17);
    send_rand(1'b1, 17);
    settle();
    chk_eq("resume_writes", wr_cnt - w0, 2);
    chk_eq("resume_overflow", OVERFLOW, 1);
    chk_eq("resume_drop_count", DROP_COUNT, 255);
    chk_eq("resume_pending", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
